// File: rtl/apu_pkg.sv
// Shared definitions for the APU channel family: waveform mode encodings,
// pulse duty thresholds, register addresses and the NES length lookup table.
package apu_pkg;

  typedef enum logic [1:0] {
    MODE_TRI   = 2'd0,
    MODE_SAW   = 2'd1,
    MODE_PULSE = 2'd2,
    MODE_RSVD  = 2'd3
  } waveMode_e;

  // Register select values on the CPU write bus.
  localparam logic [1:0] ADDR_LIN = 2'd0;
  localparam logic [1:0] ADDR_PLO = 2'd1;
  localparam logic [1:0] ADDR_LEN = 2'd2;
  localparam logic [1:0] ADDR_CFG = 2'd3;

  // Pulse high time, in eighths of a full sequencer cycle.
  localparam logic [2:0] DUTY_D0 = 3'd1;
  localparam logic [2:0] DUTY_D1 = 3'd2;
  localparam logic [2:0] DUTY_D2 = 3'd4;
  localparam logic [2:0] DUTY_D3 = 3'd6;

  localparam logic [7:0] LEN_TABLE [32] = '{
    8'd10,  8'd254, 8'd20,  8'd2,  8'd40, 8'd4,  8'd80, 8'd6,
    8'd160, 8'd8,   8'd60,  8'd10, 8'd14, 8'd12, 8'd26, 8'd14,
    8'd12,  8'd16,  8'd24,  8'd18, 8'd48, 8'd20, 8'd96, 8'd22,
    8'd192, 8'd24,  8'd72,  8'd26, 8'd16, 8'd28, 8'd32, 8'd30
  };

  function automatic logic [2:0] dutyThreshold(input logic [1:0] duty);
    logic [2:0] d;
    case (duty)
      2'd0:    d = DUTY_D0;
      2'd1:    d = DUTY_D1;
      2'd2:    d = DUTY_D2;
      default: d = DUTY_D3;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/apu_wave_channel_if.sv
// CPU-side register write bus for the APU channels.
// Handshake: a write is accepted on every rising clk edge where wr_en=1;
// there is no ready/back-pressure, the channel always takes the write, and
// wr_en must be a single-cycle strobe per register write.
interface apu_wave_channel_if;
  logic       wr_en;
  logic [1:0] wr_addr;
  logic [7:0] wr_data;

  modport master (output wr_en, wr_addr, wr_data);
  modport slave  (input  wr_en, wr_addr, wr_data);
endinterface

// File: rtl/apu_length_counter.sv
// NES-style length counter: table load, halt, enable clear and half-frame
// decrement. Shared by the wave, pulse and noise channels.
module apu_length_counter
  import apu_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       halfTick,
  input  logic       halt,
  input  logic       load,
  input  logic       clear,
  input  logic [4:0] lenIdx,
  output logic       active,
  output logic       activeNext
);

  logic [7:0] length;
  logic [7:0] lengthNext;

  // Clear beats a table load, and a load beats the half-frame decrement.
  always_comb begin
    lengthNext = length;
    if (clear) begin
      lengthNext = '0;
    end else if (load) begin
      lengthNext = LEN_TABLE[lenIdx];
    end else if (halfTick && !halt && (length != '0)) begin
      lengthNext = length - 1'b1;
    end
  end

  assign activeNext = (lengthNext != '0);

  // Counter and its nonzero flag are registered together.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      length <= '0;
      active <= 1'b0;
    end else begin
      length <= lengthNext;
      active <= activeNext;
    end
  end

endmodule

// File: rtl/apu_wave_channel.sv
// Wave channel: one timer/sequencer core producing triangle, sawtooth or
// pulse samples, gated by the linear counter and the length counter.
module apu_wave_channel
  import apu_pkg::*;
#(
  parameter int TIMER_W = 11,
  parameter int OUT_W   = 4,
  parameter int LIN_W   = 7
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               quarter_tick,
  input  logic               half_tick,
  apu_wave_channel_if.slave  bus,
  output logic [OUT_W-1:0]   sample,
  output logic               active
);

  logic               ctrl;
  logic [LIN_W-1:0]   linReload;
  logic [TIMER_W-1:0] period;
  logic [10:0]        periodWide;
  logic               enable;
  waveMode_e          mode;
  logic [1:0]         duty;

  logic               linReloadFlag;
  logic [LIN_W-1:0]   linear;
  logic [TIMER_W-1:0] timer;
  logic [OUT_W:0]     step;

  logic               wrLin, wrPlo, wrLen, wrCfg;
  logic               stepTick, linearOk, ultrasonic, stepAdvance;
  logic               activeNext;
  logic [OUT_W-1:0]   wave;

  assign wrLin = bus.wr_en && (bus.wr_addr == ADDR_LIN);
  assign wrPlo = bus.wr_en && (bus.wr_addr == ADDR_PLO);
  assign wrLen = bus.wr_en && (bus.wr_addr == ADDR_LEN);
  assign wrCfg = bus.wr_en && (bus.wr_addr == ADDR_CFG);

  // 11-bit view of the period so both halves can be written at any TIMER_W;
  // bits at or above TIMER_W fall away in the truncating casts below.
  assign periodWide = 11'(period);

  // CPU register file.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ctrl      <= 1'b0;
      linReload <= '0;
      period    <= '0;
      enable    <= 1'b0;
      mode      <= MODE_TRI;
      duty      <= 2'd0;
    end else begin
      if (wrLin) begin
        ctrl      <= bus.wr_data[7];
        linReload <= bus.wr_data[LIN_W-1:0];
      end
      if (wrPlo) begin
        period <= TIMER_W'({periodWide[10:8], bus.wr_data});
      end
      if (wrLen) begin
        period <= TIMER_W'({bus.wr_data[2:0], periodWide[7:0]});
      end
      if (wrCfg) begin
        enable <= bus.wr_data[7];
        mode   <= waveMode_e'(bus.wr_data[6:5]);
        duty   <= bus.wr_data[4:3];
      end
    end
  end

  // Linear counter on the quarter-frame strobe; an addr2 write re-arms the
  // reload flag and wins over a coincident flag clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      linear        <= '0;
      linReloadFlag <= 1'b0;
    end else begin
      if (quarter_tick) begin
        if (linReloadFlag) begin
          linear <= linReload;
        end else if (linear != '0) begin
          linear <= linear - 1'b1;
        end
      end
      if (wrLen) begin
        linReloadFlag <= 1'b1;
      end else if (quarter_tick && !ctrl) begin
        linReloadFlag <= 1'b0;
      end
    end
  end

  apu_length_counter u_length (
    .clk        (clk),
    .reset      (reset),
    .halfTick   (half_tick),
    .halt       (ctrl),
    .load       (wrLen && enable),
    .clear      (wrCfg && !bus.wr_data[7]),
    .lenIdx     (bus.wr_data[7:3]),
    .active     (active),
    .activeNext (activeNext)
  );

  assign stepTick    = (timer == '0);
  assign linearOk    = ((mode == MODE_TRI) || (mode == MODE_SAW)) ? (linear != '0) : 1'b1;
  assign ultrasonic  = (mode == MODE_TRI) && (period < TIMER_W'(2));
  assign stepAdvance = stepTick && active && linearOk && !ultrasonic;

  // Period timer and sequencer step; the step wraps naturally at 2^(OUT_W+1).
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      timer <= '0;
      step  <= '0;
    end else begin
      timer <= stepTick ? period : timer - 1'b1;
      if (stepAdvance) begin
        step <= step + 1'b1;
      end
    end
  end

  // Waveform shaping from the current step; pulse is silenced as soon as the
  // length counter reaches zero so it drops together with active.
  always_comb begin
    wave = '0;
    case (mode)
      MODE_TRI:   wave = step[OUT_W] ? step[OUT_W-1:0] : ~step[OUT_W-1:0];
      MODE_SAW:   wave = step[OUT_W:1];
      MODE_PULSE: if (activeNext && (step[OUT_W:OUT_W-2] < dutyThreshold(duty))) wave = '1;
      default:    wave = '0;
    endcase
  end

  // Registered DAC output.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sample <= '0;
    end else begin
      sample <= wave;
    end
  end

endmodule

// File: doc/apu_wave_channel.md
Name: apu_wave_channel

Overview:
- Parametrised successor to the triangle channel: one timer/sequencer core with selectable waveform mode (triangle, sawtooth, pulse), configurable sample width and timer width.
- Keeps the NES linear counter and length counter gating.
- Sits between the CPU-side register bus and the DAC.
- Consumes the frame sequencer's quarter-frame (240 Hz) and half-frame (120 Hz) strobes.

Parameters:
- TIMER_W, 11, timer period width; legal range 8..11.
- OUT_W, 4, sample width; sequencer has 2^(OUT_W+1) steps.
- LIN_W, 7, linear counter width; legal range 1..7.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset (asserted when 0)
- quarter_tick  in  1  one-cycle quarter-frame strobe (clk240)
- half_tick  in  1  one-cycle half-frame strobe (clk120)
- wr_en  in  1  register write strobe, one cycle
- wr_addr  in  2  register select
- wr_data  in  8  write data
- sample  out  OUT_W  registered channel output to DAC
- active  out  1  high while length counter is nonzero

Behaviour:
- Register map (written on clk edge when wr_en=1):
  - addr0: {ctrl, lin_reload[6:0]}; ctrl = length halt and linear control; low LIN_W bits are used.
  - addr1: period[7:0].
  - addr2: {len_idx[4:0], period[10:8]}; period bits at or above TIMER_W are ignored. If enable=1, loads length counter from LEN_TABLE[len_idx]. Always sets lin_reload_flag.
  - addr3: {enable, mode[1:0], duty[1:0], 3'b0}. enable=0 clears the length counter the same cycle.
- Reset (async, reset=0): all counters, step, period, registers, lin_reload_flag, sample and active go to 0. Mode resets to triangle.
- Timer:
  - When timer==0: reload from period and assert step_tick for one cycle. Otherwise decrement.
  - Step period is therefore period+1 clocks.
- Sequencer step (OUT_W+1 bits):
  - Advances on step_tick only when length!=0 and linear!=0; linear gating applies in triangle and saw modes only.
  - Wraps 2^(OUT_W+1)-1 -> 0.
  - In triangle mode, period<2 freezes the step (ultrasonic mute).
- Waveform, with s = step[OUT_W-1:0], msb = step[OUT_W]:
  - mode0 triangle: msb=0 -> ~s, else s. Sequence 15..0,0..15 for OUT_W=4.
  - mode1 sawtooth: step[OUT_W:1].
  - mode2 pulse: output all-ones when step[OUT_W:OUT_W-2] < D, else 0. D = 1, 2, 4, 6 for duty 0..3. Output is 0 whenever length==0.
  - mode3: reserved, output 0.
- Triangle and saw hold their last value when gated; there is no snap to zero.
- sample is registered: it reflects a step change 1 clk after the step register updates.
- Linear counter, evaluated on quarter_tick:
  - If lin_reload_flag: linear = lin_reload. Else if linear!=0: decrement.
  - Then, if ctrl==0, clear lin_reload_flag.
  - If an addr2 write coincides with quarter_tick, the flag set by the write wins; the reload happens on the next quarter tick.
- Length counter, evaluated on half_tick: if ctrl==0 and length!=0, decrement.
  - A write to addr2 in the same cycle as half_tick takes priority; the table value is loaded with no decrement.
  - An addr3 clear (enable=0) overrides everything.
- active = (length!=0), registered together with the counter.
- quarter_tick and half_tick may coincide; both counters are updated independently in that cycle.
- Reset mid-operation: immediate clear; the next tick after release uses the default state.

Decomposition:
- Package apu_pkg:
  - LEN_TABLE, the 32-entry NES length lookup (10,254,20,2,40,4,80,6,160,8,60,10,14,12,26,14,12,16,24,18,48,20,96,22,192,24,72,26,16,28,32,30).
  - Mode encodings MODE_TRI/MODE_SAW/MODE_PULSE.
  - Duty threshold constants.
- One natural sub-module: apu_length_counter (table load, halt, enable clear, half_tick decrement). It is reusable by future pulse and noise channels.

Test Plan:
- Triangle sweep (OUT_W=4):
  - Stimulus: period=10, lin_reload=100, ctrl=1, len_idx=1 (254), enable=1, one quarter_tick.
  - Required: sample steps 15,14,..0,0,1,..15, one step per 11 clk, with 1-clk output lag.
- Linear expiry:
  - Stimulus: ctrl=0, lin_reload=3, four quarter_ticks.
  - Required: linear goes 3,2,1,0. Sample freezes at its current value; active stays 1.
- Length halt and expiry:
  - Stimulus: len_idx=3 (2), ctrl=0, two half_ticks.
  - Required: active drops after the 2nd tick. With ctrl=1, length stays at 2.
- Pulse duty:
  - Stimulus: mode2, duty=2, period=4.
  - Required: sample is 15 for steps 0..15 and 0 for steps 16..31. enable=0 forces 0 and active=0 next clk.
- Priority:
  - Stimulus: addr2 write coincident with half_tick.
  - Required: length equals the table value with no decrement. A triangle period write of 1 freezes the step.
- Async reset mid-sweep:
  - Stimulus: pull reset low between clk edges.
  - Required: sample=0 and active=0 immediately; after release the channel is silent until reprogrammed.
